// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, 32x32 register file, ALU and source muxes.
// Optional build macro MC_DP_REGFILE_CLEAR_EN: reset also clears the register file asynchronously.
module mc_datapath #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcen,
    input  logic             irwrite,
    input  logic             regwrite,
    input  logic             alusrca,
    input  logic             iord,
    input  logic             memtoreg,
    input  logic             regdst,
    input  logic [1:0]       alusrcb,
    input  logic [1:0]       pcsrc,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] readdata,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             zero,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata
);

    logic [WIDTH-1:0] pc, ir, mdr, a, b, aluout;
    logic [WIDTH-1:0] rf [32];
    logic [WIDTH-1:0] rd1, rd2, wd;
    logic [4:0]       wa;
    logic [WIDTH-1:0] signimm, signimm_sh, srca, srcb, alu_result, pc_next;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign adr       = iord ? aluout : pc;
    assign writedata = b;

    // Register 0 is hardwired to zero on the read side; writes to it are dropped below.
    assign rd1 = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
    assign rd2 = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
    assign wa  = regdst ? ir[15:11] : ir[20:16];
    assign wd  = memtoreg ? mdr : aluout;

`ifdef MC_DP_REGFILE_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwrite && (wa != 5'd0)) begin
            rf[wa] <= wd;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (regwrite && (wa != 5'd0)) rf[wa] <= wd;
    end
`endif

    assign signimm    = {{(WIDTH-16){ir[15]}}, ir[15:0]};
    assign signimm_sh = {signimm[WIDTH-3:0], 2'b00};
    assign srca       = alusrca ? a : pc;

    always_comb begin
        srcb = b;
        case (alusrcb)
            2'b00: srcb = b;
            2'b01: srcb = WIDTH'(4);
            2'b10: srcb = signimm;
            2'b11: srcb = signimm_sh;
            default: srcb = b;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alucontrol)
            4'b0000: alu_result = srca & srcb;
            4'b0001: alu_result = srca | srcb;
            4'b0010: alu_result = srca + srcb;
            4'b0110: alu_result = srca - srcb;
            4'b0111: alu_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            4'b1100: alu_result = ~(srca | srcb);
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        pc_next = alu_result;
        case (pcsrc)
            2'b00: pc_next = alu_result;
            2'b01: pc_next = aluout;
            2'b10: pc_next = {pc[WIDTH-1:WIDTH-4], ir[25:0], 2'b00};
            2'b11: pc_next = aluout;
            default: pc_next = alu_result;
        endcase
    end

    // adr is taken from the pre-edge PC, so fetch can update IR and PC at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            mdr    <= readdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= alu_result;
            if (irwrite) ir <= readdata;
            if (pcen)    pc <= pc_next;
        end
    end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle MIPS datapath that executes the control words issued by `controller`. It is the neighbouring stage on both sides of the control FSM: it returns `op`, `funct` and `zero` to the controller and drives the unified instruction/data memory. It holds the PC, the instruction register (IR), the memory data register (MDR), the A/B operand registers, ALUOut and a 32x32 register file. It also contains the ALU and all source-select muxes.

## Interface
Parameters:
- `WIDTH`, 32, datapath and memory word width; only 32 is supported.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `pcen`  in  1  PC write enable
- `irwrite`  in  1  IR write enable
- `regwrite`  in  1  register file write enable
- `alusrca`  in  1  ALU A select: 0 = PC, 1 = A register
- `iord`  in  1  memory address select: 0 = PC, 1 = ALUOut
- `memtoreg`  in  1  write-back data select: 0 = ALUOut, 1 = MDR
- `regdst`  in  1  write register select: 0 = rt (IR[20:16]), 1 = rd (IR[15:11])
- `alusrcb`  in  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `pcsrc`  in  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = ALUOut
- `alucontrol`  in  4  ALU operation
- `readdata`  in  32  memory read data
- `op`  out  6  IR[31:26]
- `funct`  out  6  IR[5:0]
- `zero`  out  1  ALU result == 0 (combinational)
- `adr`  out  32  memory address
- `writedata`  out  32  memory write data, equal to the B register

## Operation
- SignImm is IR[15:0] sign-extended to 32 bits. The jump target is {PC[31:28], IR[25:0], 2'b00}.
- ALU operations, with 32-bit wrap-around arithmetic:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed compare; result 1/0), 1100 NOR.
  - Any other code gives result 0.
- Register file reads are asynchronous: RD1 = reg[IR[25:21]], RD2 = reg[IR[20:16]]. Register 0 always reads 0, and writes to it are ignored.
- Register file writes happen at the rising edge when `regwrite` is 1. The address comes from `regdst` and the data from `memtoreg`.
- A write and a read of the same register in the same cycle returns the old value. A/B capture the new value on the next edge.
- Loads at each rising edge:
  - MDR <= readdata, A <= RD1, B <= RD2, ALUOut <= ALU result. These load unconditionally.
  - IR <= readdata if `irwrite`.
  - PC <= next-PC if `pcen`.
- `adr` = `iord` ? ALUOut : PC (combinational).
- No handshake. The controller guarantees the sequencing, and the block holds no state machine of its own beyond its registers.

## Timing
- Reset (asynchronous) values:
  - PC = `RESET_PC`; IR, MDR, A, B, ALUOut = 0.
  - Consequently `op` = 0, `funct` = 0, `adr` = `RESET_PC`, `writedata` = 0.
  - `zero` follows the ALU, which is combinational from the current selects.
- Reset asserted mid-instruction clears all registers immediately. Register file contents are governed by the Configuration section.
- Fetch cycle (`irwrite`=1, `pcen`=1, `alusrca`=0, `alusrcb`=01, `pcsrc`=00, alucontrol ADD): IR and PC+4 are both updated at the same edge. The PC update must not corrupt `adr` for the IR load in that cycle.
- Instruction latency is set by the controller: lw 5 cycles, sw/R-type/addi 4, beq/j 3.
- `zero` is valid in the same cycle as the `alucontrol`/`alusrc*` settings. The branch PC update uses ALUOut, which was computed in decode.
- `writedata` is valid from the cycle after the register read, i.e. from the B load.

## Configuration
- `MC_DP_REGFILE_CLEAR_EN` defined: reset clears all 32 registers to 0, asynchronously.
- Not defined: reset does not touch the register file. Contents are X until written, and register 0 still reads 0.

## Test plan
- Reset: assert `reset` for 1 ns with `RESET_PC`=0 -> PC=0, `adr`=0, `op`=0, `funct`=0, `writedata`=0.
- Fetch: `readdata`=32'h8C08_0004 with the fetch control word, one edge -> IR=32'h8C08_0004, `op`=6'b100011, PC=4.
- lw $t0,4($zero): run the decode/memadr/memrd/memwb control words with `readdata`=32'h0000_00AB in memrd:
  - memadr -> `adr`=4 in memrd.
  - End of memwb -> reg[8]=32'hAB.
- R-type add $t2,$t0,$t0 with reg[8]=32'hAB: run rtypeEx then rtypewb with alucontrol 0010 -> reg[10]=32'h156. Also `regdst`=1 with rd=0 -> reg[0] still 0.
- beq: reg[8]==reg[8], offset 2, PC=8 after fetch. Decode computes ALUOut=16; beqex with SUB gives `zero`=1, `pcen`=1, `pcsrc`=01 -> PC=16.
- j 0x0000040 (IR=32'h0800_0010) with `pcsrc`=10, `pcen`=1 -> PC=32'h0000_0040. Also check both macro builds: with `MC_DP_REGFILE_CLEAR_EN`, reset after a write reads reg[8]=0; without it, reg[8] keeps its value.
